// File: rtl/cbrt_pkg.sv
// Shared widths, state encoding and step limit for the digit-by-digit cube-root sequencer.
package cbrt_pkg;

   localparam int DATA_W = 32;
   localparam int N_GRP  = 11;
   localparam int ROOT_W = 11;
   localparam int REM_W  = 24;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_STEP = 4'd10;

endpackage

// File: rtl/cbrt_group_sel.sv
// Selects one 3-bit operand group, MSB group first; index 0 is the zero-padded top pair.
module cbrt_group_sel
   import cbrt_pkg::*;
(
   input  logic [3:0]        idx,
   input  logic [DATA_W-1:0] x,
   output logic [2:0]        grp
);

   // A leading zero makes the operand an exact multiple of three bits.
   logic [3*N_GRP-1:0] x_pad;
   assign x_pad = {1'b0, x};

   always_comb begin
      grp = 3'd0;
      for (int i = 0; i < N_GRP; i++) begin
         if (idx == 4'(i)) grp = x_pad[3*(N_GRP-1-i) +: 3];
      end
   end

endmodule

// File: rtl/cbrt_seq_ctrl.sv
// Sequencer for the restoring integer cube root: one 3-bit group per cycle, 11 steps per result.
module cbrt_seq_ctrl
   import cbrt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] x_in,
   output logic              ready,
   output logic              busy,
   output logic              valid,
   output logic [ROOT_W-1:0] root,
   output logic [REM_W-1:0]  rem
);

   localparam int RS_W = REM_W + 3;

   state_t            state_q, state_d;
   logic [3:0]        step_q;
   logic [DATA_W-1:0] x_q;
   logic [ROOT_W-1:0] y_q, root_q;
   logic [REM_W-1:0]  r_q, rem_q;
   logic              load, adv, last;

   logic [2:0]        grp;
   logic [RS_W-1:0]   rs, ys_w, b, diff;
   logic [ROOT_W:0]   ys, ys_inc;
   logic              ge;
   logic [ROOT_W-1:0] y_nxt;
   logic [REM_W-1:0]  r_nxt;
   logic              unused_bits;

   cbrt_group_sel u_sel (
      .idx (step_q),
      .x   (x_q),
      .grp (grp)
   );

   // Restoring step: try the next root bit; keep it only if the trial subtrahend fits.
   assign rs     = {r_q, grp};
   assign ys     = {y_q, 1'b0};
   assign ys_inc = ys + 1'b1;
   assign ys_w   = RS_W'(ys);
   assign b      = RS_W'(3) * ys_w * (ys_w + RS_W'(1)) + RS_W'(1);
   assign ge     = (rs >= b);
   assign diff   = rs - b;
   assign y_nxt  = ge ? ys_inc[ROOT_W-1:0] : ys[ROOT_W-1:0];
   assign r_nxt  = ge ? diff[REM_W-1:0] : rs[REM_W-1:0];

   // The dropped high bits are provably zero for any 32-bit operand.
   assign unused_bits = ^{diff[RS_W-1:REM_W], rs[RS_W-1:REM_W], ys_inc[ROOT_W], ys[ROOT_W]};

   assign last = (step_q == LAST_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      adv     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            adv = 1'b1;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = S_ITER;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Results are captured on the final step so they are already new while valid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= 4'd0;
         x_q    <= '0;
         y_q    <= '0;
         r_q    <= '0;
         root_q <= '0;
         rem_q  <= '0;
      end else if (load) begin
         step_q <= 4'd0;
         x_q    <= x_in;
         y_q    <= '0;
         r_q    <= '0;
      end else if (adv) begin
         y_q <= y_nxt;
         r_q <= r_nxt;
         if (last) begin
            root_q <= y_nxt;
            rem_q  <= r_nxt;
         end else begin
            step_q <= step_q + 4'd1;
         end
      end
   end

   assign ready = (state_q != S_ITER);
   assign busy  = (state_q == S_ITER);
   assign valid = (state_q == S_DONE);
   assign root  = root_q;
   assign rem   = rem_q;

endmodule

// File: tb/tb_cbrt_seq_ctrl.sv
// Directed and randomized-operand bench for cbrt_seq_ctrl with hand-computed expectations.
module tb_cbrt_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] x_in;
   logic        ready, busy, valid;
   logic [10:0] root;
   logic [23:0] rem;

   int nerr = 0;
   int nchk = 0;

   cbrt_seq_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x_in  (x_in),
      .ready (ready),
      .busy  (busy),
      .valid (valid),
      .root  (root),
      .rem   (rem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called just after the accepting edge; returns cycles from start request to valid.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [31:0] x, output int lat);
      @(negedge clk);
      start = 1'b1;
      x_in  = x;
      @(posedge clk); #1;
      start = 1'b0;
      x_in  = ~x;
      wait_valid(lat);
   endtask

   task automatic op_chk(input string tag, input logic [31:0] x,
                         input logic [10:0] er, input logic [23:0] em);
      int lat;
      do_op(x, lat);
      chk({tag, "_lat"}, 64'(lat), 64'd12);
      chk({tag, "_root"}, 64'(root), 64'(er));
      chk({tag, "_rem"}, 64'(rem), 64'(em));
   endtask

   function automatic longint cbrt_ref(input logic [31:0] x);
      longint r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= longint'(x)) r++;
      return r;
   endfunction

   initial begin
      int lat;
      int npulse;
      logic [10:0] cap_root;
      logic [23:0] cap_rem;
      logic [31:0] xr;
      longint r64, x64;

      rst   = 1'b1;
      start = 1'b0;
      x_in  = 32'd0;
      #3;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_root", 64'(root), 64'd0);
      chk("rst_rem", 64'(rem), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Latency and busy/ready during iteration
      @(negedge clk);
      start = 1'b1;
      x_in  = 32'd27;
      @(posedge clk); #1;
      start = 1'b0;
      chk("x27_busy", 64'(busy), 64'd1);
      chk("x27_ready", 64'(ready), 64'd0);
      wait_valid(lat);
      chk("x27_lat", 64'(lat), 64'd12);
      chk("x27_root", 64'(root), 64'd3);
      chk("x27_rem", 64'(rem), 64'd0);
      @(posedge clk); #1;
      chk("x27_valid_1cyc", 64'(valid), 64'd0);

      op_chk("x0", 32'd0, 11'd0, 24'd0);
      op_chk("x1", 32'd1, 11'd1, 24'd0);
      op_chk("xmax", 32'hFFFF_FFFF, 11'd1625, 24'd3951670);
      op_chk("xmsb", 32'h8000_0000, 11'd1290, 24'd794648);

      // Back-to-back: new request presented during the DONE cycle
      op_chk("x999999", 32'd999999, 11'd99, 24'd29700);
      chk("done_ready", 64'(ready), 64'd1);
      start = 1'b1;
      x_in  = 32'd1000000;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_valid_low", 64'(valid), 64'd0);
      wait_valid(lat);
      chk("b2b_lat", 64'(lat), 64'd12);
      chk("b2b_root", 64'(root), 64'd100);
      chk("b2b_rem", 64'(rem), 64'd0);

      // A request during ITER must be ignored
      @(negedge clk);
      start = 1'b1;
      x_in  = 32'd64;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      x_in  = 32'd8;
      @(posedge clk); #1;
      start = 1'b0;
      npulse = 0;
      cap_root = '0;
      cap_rem  = '1;
      repeat (30) begin
         @(posedge clk); #1;
         if (valid) begin
            npulse++;
            cap_root = root;
            cap_rem  = rem;
         end
      end
      chk("ign_pulses", 64'(npulse), 64'd1);
      chk("ign_root", 64'(cap_root), 64'd4);
      chk("ign_rem", 64'(cap_rem), 64'd0);

      // Reset mid-iteration
      @(negedge clk);
      start = 1'b1;
      x_in  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_root", 64'(root), 64'd0);
      chk("abort_rem", 64'(rem), 64'd0);
      chk("abort_ready", 64'(ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      npulse = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (valid) npulse++;
      end
      chk("abort_no_valid", 64'(npulse), 64'd0);
      chk("abort_idle_ready", 64'(ready), 64'd1);
      chk("abort_root_held", 64'(root), 64'd0);
      op_chk("x125", 32'd125, 11'd5, 24'd0);

      // Exact cubes and their predecessors
      for (int k = 2; k <= 1625; k += 203) begin
         xr = 32'(k * k * k);
         op_chk("cube", xr, 11'(k), 24'd0);
         op_chk("cube_m1", xr - 32'd1, 11'(k - 1), 24'(xr - 32'd1 - 32'((k-1)*(k-1)*(k-1))));
      end

      // Random operands against the reference model
      for (int i = 0; i < 250; i++) begin
         xr = $urandom;
         if (i % 3 == 0) xr = xr >> $urandom_range(31, 0);
         do_op(xr, lat);
         x64 = longint'(xr);
         r64 = longint'(root);
         chk("rnd_lat", 64'(lat), 64'd12);
         chk("rnd_root", 64'(root), 64'(cbrt_ref(xr)));
         chk("rnd_lo", 64'(r64 * r64 * r64 <= x64), 64'd1);
         chk("rnd_hi", 64'(x64 < (r64 + 1) * (r64 + 1) * (r64 + 1)), 64'd1);
         chk("rnd_rem", 64'(rem), 64'(x64 - r64 * r64 * r64));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
